// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner:
// segment patterns, the anode-off pattern and the scan FSM encoding.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   // Active-low {g,f,e,d,c,b,a} patterns, indexed by the hex value shown
   localparam logic [6:0] HEX_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Digit i (i >= 1) goes dark when it and every digit above it are zero
   function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i,
                                     input logic lzs);
      return lzs && (i != 2'd0) && ((v >> {i, 2'b00}) == 16'd0);
   endfunction

endpackage

// File: rtl/display_scanner_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg
   import display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display,
// with a per-digit blanking guard and once-per-frame latching of the value.
module display_scanner
   import display_pkg::*;
#(
   parameter int BLANK_CYCLES = 16,
   parameter int CNT_W        = 5
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_display,
   input  logic        en,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic        lzs,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
   logic             cd_q;
   logic [15:0]      sh_value_q, sh_value_d;
   logic [3:0]       sh_dp_q, sh_dp_d;
   logic             sh_lzs_q, sh_lzs_d;

   logic             tick, advance, latch;
   logic [3:0]       nibble;
   logic [6:0]       dec_seg;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;

   assign tick = clk_display & ~cd_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      blank_cnt_d = blank_cnt_q;
      advance     = 1'b0;
      latch       = 1'b0;

      if (!en) begin
         state_d     = ST_IDLE;
         idx_d       = 2'd0;
         blank_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tick) begin
                  idx_d   = 2'd0;
                  latch   = 1'b1;
                  advance = 1'b1;
               end
            end
            ST_BLANK: begin
               if (blank_cnt_q == '0) state_d = ST_DRIVE;
               else                   blank_cnt_d = blank_cnt_q - 1'b1;
            end
            ST_DRIVE: begin
               if (tick) begin
                  idx_d   = idx_q + 2'd1;
                  latch   = (idx_q == 2'd3);
                  advance = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A digit change either opens the guard window or, with no guard, drives at once
      if (advance) begin
         if (BLANK_CYCLES == 0) begin
            state_d = ST_DRIVE;
         end else begin
            state_d     = ST_BLANK;
            blank_cnt_d = BLANK_LOAD;
         end
      end
   end

   always_comb begin
      sh_value_d = sh_value_q;
      sh_dp_d    = sh_dp_q;
      sh_lzs_d   = sh_lzs_q;
      if (latch) begin
         sh_value_d = value;
         sh_dp_d    = dp_mask;
         sh_lzs_d   = lzs;
      end
   end

   // Decode from the next-cycle shadow so a frame latch and its first digit agree
   assign nibble = sh_value_d[{idx_d, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (dec_seg)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_d == ST_DRIVE) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = lz_blank(sh_value_d, idx_d, sh_lzs_d) ? SEG_BLANK : dec_seg;
         dp_d  = ~sh_dp_d[idx_d];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         blank_cnt_q <= '0;
         cd_q        <= 1'b0;
         sh_value_q  <= 16'd0;
         sh_dp_q     <= 4'd0;
         sh_lzs_q    <= 1'b0;
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
         frame_done  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         blank_cnt_q <= blank_cnt_d;
         cd_q        <= clk_display;
         sh_value_q  <= sh_value_d;
         sh_dp_q     <= sh_dp_d;
         sh_lzs_q    <= sh_lzs_d;
         an          <= an_d;
         seg         <= seg_d;
         dp          <= dp_d;
         frame_done  <= latch;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: one instance with a 16-cycle guard and
// one with no guard share stimulus; a frame-level model predicts each digit shown.
module tb_display_scanner;

   localparam int NB = 2;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_display;
   logic        en;
   logic [15:0] value;
   logic [3:0]  dp_mask;
   logic        lzs;

   logic [3:0]  an_o  [NB];
   logic [6:0]  seg_o [NB];
   logic        dp_o  [NB];
   logic        fd_o  [NB];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   exp_t dq [NB][$];
   int   fq [NB][$];

   bit          act  [NB];
   int          dig  [NB];
   int          busy [NB];
   logic [15:0] sv   [NB];
   logic [3:0]  sdp  [NB];
   logic        slz  [NB];

   logic [3:0]  prev_an [NB];
   exp_t        ev;
   int          fcyc;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   display_scanner #(.BLANK_CYCLES(16), .CNT_W(5)) dut16 (
      .clk(clk), .rst(rst), .clk_display(clk_display), .en(en), .value(value),
      .dp_mask(dp_mask), .lzs(lzs), .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0]),
      .frame_done(fd_o[0]));

   display_scanner #(.BLANK_CYCLES(0), .CNT_W(1)) dut0 (
      .clk(clk), .rst(rst), .clk_display(clk_display), .en(en), .value(value),
      .dp_mask(dp_mask), .lzs(lzs), .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1]),
      .frame_done(fd_o[1]));

   function automatic int bc(input int k);
      return (k == 0) ? 16 : 0;
   endfunction

   function automatic logic [6:0] hexseg(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] got,
                      input logic [31:0] want);
      n_assert++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cyc %0d)", name, k, got, want, cyc);
      end
   endtask

   task automatic fail_evt(input string name, input int k);
      n_assert++;
      n_fail++;
      $display("FAIL %s dut%0d: event not matched (cyc %0d)", name, k, cyc);
   endtask

   // Frame-level prediction for a scan tick that the DUTs sample at edge e
   task automatic model_tick(input int e);
      exp_t x;
      logic [15:0] upper;
      for (int k = 0; k < NB; k++) begin
         if (!en) begin
            act[k] = 1'b0;
         end else begin
            if (!act[k]) begin
               act[k] = 1'b1;
               dig[k] = 0;
            end else if (bc(k) > 0 && e <= busy[k]) begin
               continue;
            end else begin
               dig[k] = (dig[k] + 1) % 4;
            end
            if (dig[k] == 0) begin
               sv[k]  = value;
               sdp[k] = dp_mask;
               slz[k] = lzs;
               fq[k].push_back(e);
            end
            busy[k] = e + bc(k) + 1;
            upper   = sv[k] >> (4 * dig[k]);
            x.an    = 4'hF ^ (4'b0001 << dig[k]);
            x.seg   = (slz[k] && dig[k] > 0 && upper == 16'd0) ? 7'b1111111
                                                               : hexseg(upper[3:0]);
            x.dp    = ~sdp[k][dig[k]];
            x.cyc   = (bc(k) > 0) ? e + bc(k) + 1 : e;
            dq[k].push_back(x);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick(input int gap);
      clk_display = 1'b1;
      model_tick(cyc + 1);
      idle(1);
      clk_display = 1'b0;
      idle(gap);
   endtask

   task automatic drop_en();
      en = 1'b0;
      for (int k = 0; k < NB; k++) act[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NB; k++) begin
         chk("en_off_an", k, an_o[k], 4'hF);
         chk("en_off_seg", k, seg_o[k], 7'h7F);
      end
      idle(1);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < NB; k++) begin
            if (fd_o[k]) begin
               if (fq[k].size() == 0) fail_evt("frame_done_unexpected", k);
               else begin
                  fcyc = fq[k].pop_front();
                  chk("frame_done_cyc", k, cyc, fcyc);
               end
            end
            while (fq[k].size() > 0 && fq[k][0] < cyc) begin
               fail_evt("frame_done_missing", k);
               void'(fq[k].pop_front());
            end
            if (an_o[k] != 4'hF && an_o[k] != prev_an[k]) begin
               if (dq[k].size() == 0) fail_evt("digit_unexpected", k);
               else begin
                  ev = dq[k].pop_front();
                  chk("digit_an", k, an_o[k], ev.an);
                  chk("digit_seg", k, seg_o[k], ev.seg);
                  chk("digit_dp", k, dp_o[k], ev.dp);
                  chk("digit_cyc", k, cyc, ev.cyc);
               end
            end
            while (dq[k].size() > 0 && dq[k][0].cyc < cyc) begin
               fail_evt("digit_missing", k);
               void'(dq[k].pop_front());
            end
         end
      end
      for (int k = 0; k < NB; k++) prev_an[k] = an_o[k];
   end

   initial begin
      logic [15:0] r;
      rst = 1'b0; clk_display = 1'b0; en = 1'b0;
      value = 16'h0; dp_mask = 4'h0; lzs = 1'b0;
      for (int k = 0; k < NB; k++) act[k] = 1'b0;
      idle(3);
      @(negedge clk);
      for (int k = 0; k < NB; k++) begin
         chk("reset_an", k, an_o[k], 4'hF);
         chk("reset_seg", k, seg_o[k], 7'h7F);
         chk("reset_dp", k, dp_o[k], 1'b1);
         chk("reset_frame_done", k, fd_o[k], 1'b0);
      end
      idle(1);
      rst = 1'b1; en = 1'b1; value = 16'h1234;
      idle(3);
      for (int i = 0; i < 4; i++) tick(25);

      value = 16'hBEEF; dp_mask = 4'b0100;
      for (int i = 0; i < 4; i++) tick(25);

      value = 16'h0070; dp_mask = 4'b0000; lzs = 1'b1;
      for (int i = 0; i < 4; i++) tick(25);
      value = 16'h0000;
      for (int i = 0; i < 4; i++) tick(25);

      value = 16'h1111; lzs = 1'b0;
      tick(25);
      tick(25);
      value = 16'h2222;
      for (int i = 0; i < 3; i++) tick(25);

      drop_en();
      en = 1'b1;
      idle(2);
      tick(25);
      tick(25);
      clk_display = 1'b1; en = 1'b0;
      model_tick(cyc + 1);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < NB; k++) chk("tick_en_fall_an", k, an_o[k], 4'hF);
      idle(1);
      clk_display = 1'b0;
      idle(2);
      en = 1'b1;
      idle(2);
      tick(25);
      tick(25);

      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      for (int k = 0; k < NB; k++) begin
         chk("async_rst_an", k, an_o[k], 4'hF);
         chk("async_rst_seg", k, seg_o[k], 7'h7F);
         chk("async_rst_dp", k, dp_o[k], 1'b1);
         act[k] = 1'b0;
      end
      idle(2);
      rst = 1'b1;
      idle(2);

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            r       = 16'($urandom());
            value   = r >> (4 * $urandom_range(0, 3));
            dp_mask = 4'($urandom());
            lzs     = 1'($urandom());
         end
         if ($urandom_range(0, 15) == 0) begin
            idle(20);
            drop_en();
            idle($urandom_range(0, 3));
            en = 1'b1;
            idle(1);
         end
         tick($urandom_range(2, 24));
      end

      idle(30);
      for (int k = 0; k < NB; k++) begin
         chk("digit_queue_drained", k, dq[k].size(), 0);
         chk("frame_queue_drained", k, fq[k].size(), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
